rect_plotter: RTL and testbench

Pixel-walking stage directly downstream of the game display controller. It accepts one rectangle-fill command at a time, given as origin, size and colour, and walks every covered pixel in raster order. It emits one pixel write per cycle to the VGA frame-buffer adapter. The display controller uses it for screen clears (START/WINGAME/LOSTGAME backgrounds) and for drawing gallows, body parts and letter slots (INGAME).

---
 rtl/rect_plotter.sv | 179 +++++++++++++++++
 tb/tb_rect_plotter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_plotter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rect_plotter
//  Description : Rectangle-fill pixel walker. Accepts one (origin, size,
//                colour) command at a time, clips it to the visible screen
//                and emits one pixel write per cycle in raster order.
//  Revision    : 1.0 - initial release
// ============================================================================
module rect_plotter #(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [8:0]          req_x,
    input  logic [7:0]          req_y,
    input  logic [8:0]          req_w,
    input  logic [7:0]          req_h,
    input  logic [COLOUR_W-1:0] req_colour,
    output logic                plot,
    output logic [8:0]          plot_x,
    output logic [7:0]          plot_y,
    output logic [COLOUR_W-1:0] plot_colour,
    output logic                busy,
    output logic                done
);

    localparam logic [9:0] c_X_LIM = 10'(SCREEN_W);
    localparam logic [8:0] c_Y_LIM = 9'(SCREEN_H);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state,  w_state_nxt;
    logic                  r_ready,  w_ready_nxt;
    logic                  r_plot,   w_plot_nxt;
    logic [8:0]            r_plot_x, w_plot_x_nxt;
    logic [7:0]            r_plot_y, w_plot_y_nxt;
    logic [COLOUR_W-1:0]   r_plot_c, w_plot_c_nxt;
    logic                  r_busy,   w_busy_nxt;
    logic                  r_done,   w_done_nxt;
    logic [8:0]            r_x0,     w_x0_nxt;
    logic [9:0]            r_x_end,  w_x_end_nxt;
    logic [8:0]            r_y_end,  w_y_end_nxt;
    logic [COLOUR_W-1:0]   r_fill,   w_fill_nxt;

    // Sums are one bit wider than the operands so nothing wraps before clipping
    logic [9:0] w_x_sum;
    logic [8:0] w_y_sum;
    logic [9:0] w_x_end_clip;
    logic [8:0] w_y_end_clip;
    logic       w_zero_area;
    logic       w_x_last;
    logic       w_y_last;

    // Clipped end coordinates, degenerate-command detect and raster-end detect
    always_comb begin
        w_x_sum      = {1'b0, req_x} + {1'b0, req_w};
        w_y_sum      = {1'b0, req_y} + {1'b0, req_h};
        w_x_end_clip = (w_x_sum > c_X_LIM) ? c_X_LIM : w_x_sum;
        w_y_end_clip = (w_y_sum > c_Y_LIM) ? c_Y_LIM : w_y_sum;
        w_zero_area  = (req_w == 9'd0) || (req_h == 8'd0) ||
                       ({1'b0, req_x} >= c_X_LIM) || ({1'b0, req_y} >= c_Y_LIM);
        w_x_last     = (({1'b0, r_plot_x} + 10'd1) == r_x_end);
        w_y_last     = (({1'b0, r_plot_y} + 9'd1) == r_y_end);
    end

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        w_state_nxt  = r_state;
        w_ready_nxt  = r_ready;
        w_plot_nxt   = 1'b0;
        w_plot_x_nxt = r_plot_x;
        w_plot_y_nxt = r_plot_y;
        w_plot_c_nxt = r_plot_c;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_x0_nxt     = r_x0;
        w_x_end_nxt  = r_x_end;
        w_y_end_nxt  = r_y_end;
        w_fill_nxt   = r_fill;
        case (r_state)
            S_IDLE: begin
                if (req_valid && r_ready) begin
                    w_ready_nxt = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_x0_nxt    = req_x;
                    w_x_end_nxt = w_x_end_clip;
                    w_y_end_nxt = w_y_end_clip;
                    w_fill_nxt  = req_colour;
                    if (w_zero_area) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        // First pixel goes out straight from the accept edge
                        w_state_nxt  = S_DRAW;
                        w_plot_nxt   = 1'b1;
                        w_plot_x_nxt = req_x;
                        w_plot_y_nxt = req_y;
                        w_plot_c_nxt = req_colour;
                    end
                end
            end
            S_DRAW: begin
                if (w_x_last && w_y_last) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_plot_nxt   = 1'b1;
                    w_plot_c_nxt = r_fill;
                    if (w_x_last) begin
                        w_plot_x_nxt = r_x0;
                        w_plot_y_nxt = r_plot_y + 8'd1;
                    end else begin
                        w_plot_x_nxt = r_plot_x + 9'd1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_ready_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ready_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset wins over any pending request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_plot   <= 1'b0;
            r_plot_x <= '0;
            r_plot_y <= '0;
            r_plot_c <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_x0     <= '0;
            r_x_end  <= '0;
            r_y_end  <= '0;
            r_fill   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ready  <= w_ready_nxt;
            r_plot   <= w_plot_nxt;
            r_plot_x <= w_plot_x_nxt;
            r_plot_y <= w_plot_y_nxt;
            r_plot_c <= w_plot_c_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_x0     <= w_x0_nxt;
            r_x_end  <= w_x_end_nxt;
            r_y_end  <= w_y_end_nxt;
            r_fill   <= w_fill_nxt;
        end
    end

    assign req_ready   = r_ready;
    assign plot        = r_plot;
    assign plot_x      = r_plot_x;
    assign plot_y      = r_plot_y;
    assign plot_colour = r_plot_c;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rect_plotter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_rect_plotter
//  Description : Self-checking bench for rect_plotter: table of rectangle
//                commands with hand-computed clipped bounds, plus directed
//                back-to-back, mid-draw reset and reset-priority sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rect_plotter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [8:0] req_x;
    logic [7:0] req_y;
    logic [8:0] req_w;
    logic [7:0] req_h;
    logic [2:0] req_colour;
    logic       plot;
    logic [8:0] plot_x;
    logic [7:0] plot_y;
    logic [2:0] plot_colour;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    rect_plotter #(.SCREEN_W(320), .SCREEN_H(240), .COLOUR_W(3)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
        .req_colour(req_colour),
        .plot(plot), .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // x, y, w, h, colour, expected clipped x_end/y_end, expected pixel count
    typedef struct {
        int x; int y; int w; int h; int col;
        int xe; int ye; int n;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_cmd(input int x, input int y, input int w, input int h, input int c);
        req_x      = 9'(x);
        req_y      = 8'(y);
        req_w      = 9'(w);
        req_h      = 8'(h);
        req_colour = 3'(c);
    endtask

    // Issue one command and follow it until ready returns, checking every cycle
    task automatic run_cmd(input vec_t v, input string tag);
        int wait_cyc, n_plot, first_i, done_i, done_cnt, pix_err;
        int rdy_err, busy_err, ex, ey;
        logic ready_end, busy_end;
        logic [8:0] hold_x;
        logic [7:0] hold_y;
        @(negedge clk);
        set_cmd(v.x, v.y, v.w, v.h, v.col);
        req_valid = 1'b1;
        wait_cyc = 0;
        while (req_ready !== 1'b1 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk({tag, " ready_before"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        ex = v.x; ey = v.y;
        n_plot = 0; first_i = -1; done_i = -1; done_cnt = 0; pix_err = 0;
        rdy_err = 0; busy_err = 0; ready_end = 1'b0; busy_end = 1'b1;
        hold_x = '0; hold_y = '0;
        for (int i = 1; i <= v.n + 2; i++) begin
            @(negedge clk);
            if (plot === 1'b1) begin
                n_plot++;
                if (first_i < 0) first_i = i;
                if (plot_x !== 9'(ex) || plot_y !== 8'(ey) || plot_colour !== 3'(v.col) ||
                    plot_x >= 9'd320 || plot_y >= 8'd240)
                    pix_err++;
                ex++;
                if (ex == v.xe) begin
                    ex = v.x;
                    ey++;
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_i = i;
            end
            if (i <= v.n + 1) begin
                if (req_ready !== 1'b0) rdy_err++;
                if (busy !== 1'b1) busy_err++;
            end else begin
                ready_end = req_ready;
                busy_end  = busy;
            end
            if (i == v.n + 1) begin
                hold_x = plot_x;
                hold_y = plot_y;
            end
        end
        chk({tag, " plot_count"}, 32'(n_plot), 32'(v.n));
        if (v.n > 0) begin
            chk({tag, " first_plot_cycle"}, 32'(first_i), 32'd1);
            chk({tag, " hold_x"}, 32'(hold_x), 32'(v.xe - 1));
            chk({tag, " hold_y"}, 32'(hold_y), 32'(v.ye - 1));
        end
        chk({tag, " pixel_errors"}, 32'(pix_err), 32'd0);
        chk({tag, " done_cycle"}, 32'(done_i), 32'(v.n + 1));
        chk({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, " ready_low_errs"}, 32'(rdy_err), 32'd0);
        chk({tag, " busy_high_errs"}, 32'(busy_err), 32'd0);
        chk({tag, " ready_return"}, 32'(ready_end), 32'd1);
        chk({tag, " busy_return"}, 32'(busy_end), 32'd0);
    endtask

    // Hard time limit: the longest command is a full-screen clear
    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        vecs[0]  = '{10, 20, 3, 2, 5, 13, 22, 6};
        vecs[1]  = '{0, 0, 320, 240, 0, 320, 240, 76800};
        vecs[2]  = '{318, 238, 5, 5, 6, 320, 240, 4};
        vecs[3]  = '{7, 7, 0, 5, 2, 0, 0, 0};
        vecs[4]  = '{400, 10, 4, 4, 1, 0, 0, 0};
        vecs[5]  = '{100, 239, 300, 10, 7, 320, 240, 220};
        vecs[6]  = '{0, 0, 1, 1, 3, 1, 1, 1};
        vecs[7]  = '{5, 6, 4, 0, 4, 0, 0, 0};
        vecs[8]  = '{10, 250, 3, 3, 1, 0, 0, 0};
        vecs[9]  = '{319, 0, 1, 3, 4, 320, 3, 3};
        vecs[10] = '{511, 255, 511, 255, 2, 0, 0, 0};
        vecs[11] = '{300, 200, 511, 255, 5, 320, 240, 800};

        reset = 1'b1;
        req_valid = 1'b0;
        set_cmd(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset plot", 32'(plot), 32'd0);
        chk("reset plot_x", 32'(plot_x), 32'd0);
        chk("reset plot_y", 32'(plot_y), 32'd0);
        chk("reset plot_colour", 32'(plot_colour), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);

        for (int k = 0; k < 12; k++)
            run_cmd(vecs[k], $sformatf("vec%0d", k));

        // Back-to-back: second command waits with valid high behind a 1x1
        @(negedge clk);
        set_cmd(0, 0, 1, 1, 3);
        req_valid = 1'b1;
        chk("b2b ready0", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 set_cmd(20, 30, 2, 1, 6);
        @(negedge clk);
        chk("b2b c1 plot", 32'(plot), 32'd1);
        chk("b2b c1 xy", {15'd0, plot_x, plot_y}, {15'd0, 9'd0, 8'd0});
        chk("b2b c1 ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("b2b c1 done", 32'(done), 32'd1);
        chk("b2b c1 gap", 32'(plot), 32'd0);
        @(negedge clk);
        chk("b2b ready_back", 32'(req_ready), 32'd1);
        chk("b2b no_plot", 32'(plot), 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("b2b c2 p1", {14'd0, plot, plot_x, plot_y}, {14'd0, 1'b1, 9'd20, 8'd30});
        chk("b2b c2 colour", 32'(plot_colour), 32'd6);
        @(negedge clk);
        chk("b2b c2 p2", {14'd0, plot, plot_x, plot_y}, {14'd0, 1'b1, 9'd21, 8'd30});
        @(negedge clk);
        chk("b2b c2 done", {30'd0, done, plot}, {30'd0, 1'b1, 1'b0});
        repeat (2) @(negedge clk);

        // Reset at the third pixel of a 4x4 command
        set_cmd(50, 60, 4, 4, 2);
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid third_pixel", {14'd0, plot, plot_x, plot_y}, {14'd0, 1'b1, 9'd52, 8'd60});
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid plot", 32'(plot), 32'd0);
        chk("mid done", 32'(done), 32'd0);
        chk("mid ready", 32'(req_ready), 32'd1);
        chk("mid busy", 32'(busy), 32'd0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (plot !== 1'b0 || done !== 1'b0) cnt++;
        end
        chk("mid quiet", 32'(cnt), 32'd0);
        run_cmd('{5, 5, 1, 1, 4, 6, 6, 1}, "after_reset");

        // Reset together with a request: the request must be dropped
        @(negedge clk);
        set_cmd(1, 1, 2, 2, 7);
        req_valid = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("prio busy", 32'(busy), 32'd0);
        chk("prio ready", 32'(req_ready), 32'd1);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (plot !== 1'b0 || done !== 1'b0 || busy !== 1'b0) cnt++;
        end
        chk("prio quiet", 32'(cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
